// File: rtl/ofifo_pkg.sv
// Shared accelerator constants for the MAC-array output path.
//   COL         : number of array columns / FIFO lanes
//   PSUM_BW     : bits per column partial sum
//   OFIFO_DEPTH : entries per column FIFO (power of 2, >= 2)
//   lane_of     : extract lane c from a packed COL*PSUM_BW bus
package ofifo_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 8;

    function automatic logic [PSUM_BW-1:0] lane_of(
        input logic [PSUM_BW*COL-1:0] bus,
        input int unsigned            c
    );
        return bus[PSUM_BW*c +: PSUM_BW];
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-lane circular FIFO used for one array column.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (pointers and count only)
//   wr    : write strobe; ignored when the lane is full
//   rd    : pop strobe; caller guarantees the lane is non-empty
//   din   : write data
//   dout  : head entry (first-word-fall-through, not gated)
//   count : number of stored entries, 0..depth
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int width = PSUM_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic [$clog2(depth):0]   count
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_ok;

    // Fullness is judged on the pre-pop count, so a write to a full
    // lane is dropped even when a pop happens on the same edge.
    assign wr_ok = wr && (count != FULL_CNT);

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd)
                rptr <= rptr + 1'b1;
            case ({wr_ok, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/ofifo.sv
// Output FIFO between the MAC array and the SFU. Each column is buffered
// independently; a row is presented once every column holds data.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   wr_i     : per-column write strobes
//   psum_in  : packed column data, lane c at [psum_bw*(c+1)-1 : psum_bw*c]
//   rd_i     : pop one aligned row
//   psum_out : head of every column, zero while no full row is available
//   valid_o  : every column holds at least one entry
//   full_o   : some column holds depth entries
//   ready_o  : no column is full
//   ovf_o    : sticky, a write hit a full column
//   udf_o    : sticky, rd_i asserted while valid_o was low
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col-1:0]           wr_i,
    input  logic [psum_bw*col-1:0]   psum_in,
    input  logic                     rd_i,
    output logic [psum_bw*col-1:0]   psum_out,
    output logic                     valid_o,
    output logic                     full_o,
    output logic                     ready_o,
    output logic                     ovf_o,
    output logic                     udf_o
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [psum_bw*col-1:0] head;
    logic [col-1:0]         lane_ne;
    logic [col-1:0]         lane_full;
    logic                   pop;

    assign pop = rd_i && valid_o;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [AW:0] cnt;

        ofifo_col #(
            .width (psum_bw),
            .depth (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr_i[c]),
            .rd    (pop),
            .din   (psum_in[psum_bw*c +: psum_bw]),
            .dout  (head[psum_bw*c +: psum_bw]),
            .count (cnt)
        );

        assign lane_ne[c]   = (cnt != '0);
        assign lane_full[c] = (cnt == FULL_CNT);
    end

    assign valid_o  = &lane_ne;
    assign full_o   = |lane_full;
    assign ready_o  = ~full_o;
    assign psum_out = valid_o ? head : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (|(wr_i & lane_full))
                ovf_o <= 1'b1;
            if (rd_i && !valid_o)
                udf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: queue-based reference model compared on
// every falling edge, plus directed checks with literal expectations.
module tb_ofifo;
    import ofifo_pkg::*;

    localparam int W = PSUM_BW * COL;

    logic           clk;
    logic           reset;
    logic [COL-1:0] wr_i;
    logic [W-1:0]   psum_in;
    logic           rd_i;
    logic [W-1:0]   psum_out;
    logic           valid_o, full_o, ready_o, ovf_o, udf_o;

    int n_cmp;
    int n_mis;
    bit run_cmp;

    ofifo #(
        .col     (COL),
        .psum_bw (PSUM_BW),
        .depth   (OFIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_i     (wr_i),
        .psum_in  (psum_in),
        .rd_i     (rd_i),
        .psum_out (psum_out),
        .valid_o  (valid_o),
        .full_o   (full_o),
        .ready_o  (ready_o),
        .ovf_o    (ovf_o),
        .udf_o    (udf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [PSUM_BW-1:0] mq [COL][$];
    bit m_ovf, m_udf;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            int  sz [COL];
            bit  all_ne;
            all_ne = 1;
            for (int c = 0; c < COL; c++) begin
                sz[c] = mq[c].size();
                if (sz[c] == 0) all_ne = 0;
            end
            if (rd_i) begin
                if (all_ne)
                    for (int c = 0; c < COL; c++) void'(mq[c].pop_front());
                else
                    m_udf = 1;
            end
            for (int c = 0; c < COL; c++) begin
                if (wr_i[c]) begin
                    if (sz[c] < OFIFO_DEPTH) mq[c].push_back(lane_of(psum_in, c));
                    else m_ovf = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // one compare process against the model, every falling edge
    always @(negedge clk) begin
        if (run_cmp) begin
            bit e_valid, e_full;
            logic [W-1:0] e_psum;
            e_valid = 1;
            e_full  = 0;
            for (int c = 0; c < COL; c++) begin
                if (mq[c].size() == 0) e_valid = 0;
                if (mq[c].size() == OFIFO_DEPTH) e_full = 1;
            end
            e_psum = '0;
            if (e_valid)
                for (int c = 0; c < COL; c++) e_psum[PSUM_BW*c +: PSUM_BW] = mq[c][0];
            chk("model_psum",  psum_out, e_psum);
            chk("model_valid", W'(valid_o), W'(e_valid));
            chk("model_full",  W'(full_o),  W'(e_full));
            chk("model_ready", W'(ready_o), W'(!e_full));
            chk("model_ovf",   W'(ovf_o),   W'(m_ovf));
            chk("model_udf",   W'(udf_o),   W'(m_udf));
        end
    end

    // drive inputs between edges, hold over one rising edge, then idle
    task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
        wr_i    = w;
        psum_in = d;
        rd_i    = r;
        @(posedge clk);
        #1;
        wr_i = '0;
        rd_i = 1'b0;
    endtask

    function automatic logic [W-1:0] rep(input logic [PSUM_BW-1:0] v);
        return {COL{v}};
    endfunction

    logic [W-1:0] d;

    initial begin
        n_cmp = 0;
        n_mis = 0;
        run_cmp = 0;
        reset = 1'b1;
        wr_i = '0;
        psum_in = '0;
        rd_i = 1'b0;
        #12;
        run_cmp = 1;
        chk("reset_valid", W'(valid_o), W'(0));
        chk("reset_ready", W'(ready_o), W'(1));
        chk("reset_psum",  psum_out, '0);
        reset = 1'b0;
        @(negedge clk);

        // aligned write
        for (int c = 0; c < COL; c++) d[PSUM_BW*c +: PSUM_BW] = PSUM_BW'(c + 1);
        step('1, d, 0);
        @(negedge clk);
        chk("aligned_valid", W'(valid_o), W'(1));
        chk("aligned_psum", psum_out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        step('0, '0, 1);
        @(negedge clk);
        chk("aligned_pop_valid", W'(valid_o), W'(0));
        chk("aligned_pop_psum", psum_out, '0);

        // skewed write
        for (int k = 0; k < COL; k++) begin
            d = '0;
            d[PSUM_BW*k +: PSUM_BW] = PSUM_BW'(16'h00A0 + k);
            step(COL'(1) << k, d, 0);
            @(negedge clk);
            chk("skew_valid", W'(valid_o), W'(k == COL - 1));
        end
        chk("skew_psum", psum_out, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
        step('0, '0, 1);
        @(negedge clk);

        // underflow
        step('0, '0, 1);
        @(negedge clk);
        chk("udf_set", W'(udf_o), W'(1));
        step('1, rep(16'h5A5A), 0);
        @(negedge clk);
        chk("udf_after_psum", psum_out, rep(16'h5A5A));
        step('0, '0, 1);
        @(negedge clk);
        chk("udf_sticky", W'(udf_o), W'(1));

        // overflow on lane 0
        for (int i = 0; i < OFIFO_DEPTH; i++) step(8'h01, W'(16'h0010 + i), 0);
        @(negedge clk);
        chk("ovf_full",  W'(full_o),  W'(1));
        chk("ovf_ready", W'(ready_o), W'(0));
        chk("ovf_valid", W'(valid_o), W'(0));
        chk("ovf_pre",   W'(ovf_o),   W'(0));
        step(8'h01, W'(16'h0018), 1);
        @(negedge clk);
        chk("ovf_set", W'(ovf_o), W'(1));
        chk("ovf_still_full", W'(full_o), W'(1));
        for (int i = 0; i < OFIFO_DEPTH; i++) step(8'hFE, rep(PSUM_BW'(16'h0100 + i)), 0);
        for (int i = 0; i < OFIFO_DEPTH; i++) begin
            @(negedge clk);
            chk("ovf_lane0", W'(lane_of(psum_out, 0)), W'(16'h0010 + i));
            step('0, '0, 1);
        end
        @(negedge clk);
        chk("ovf_drained", W'(valid_o), W'(0));

        // wrap-around with simultaneous write and pop
        step('1, rep(16'd0), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("wrap_psum", psum_out, rep(PSUM_BW'(i)));
            chk("wrap_full", W'(full_o), W'(0));
            step('1, rep(PSUM_BW'(i + 1)), 1);
        end
        @(negedge clk);
        chk("wrap_last", psum_out, rep(16'd20));
        step('0, '0, 1);

        // reset mid-operation
        for (int i = 0; i < 3; i++) step('1, rep(PSUM_BW'(16'h0300 + i)), 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", W'(valid_o), W'(0));
        chk("rst_mid_psum", psum_out, '0);
        chk("rst_mid_ovf",  W'(ovf_o), W'(0));
        @(negedge clk);
        reset = 1'b0;
        step('1, rep(16'h1234), 0);
        @(negedge clk);
        chk("rst_after_psum", psum_out, rep(16'h1234));
        step('0, '0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [COL-1:0] w;
            w = COL'($urandom);
            if ($urandom_range(3) == 0) w = '1;
            for (int c = 0; c < COL; c++) d[PSUM_BW*c +: PSUM_BW] = PSUM_BW'($urandom);
            step(w, d, 1'($urandom_range(1)));
        end

        @(negedge clk);
        run_cmp = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output FIFO between the 8x8 MAC array and the SFU.
- The array emits per-column partial sums at skewed cycles. This block buffers each column independently and presents a full aligned row to the SFU's psum_in once every column holds data.
- The controller pops rows and drives the SFU's acc_i and psum_bypass_i alongside each popped row.

Parameters:
- col, 8, number of columns / independent lanes
- psum_bw, 16, bits per column partial sum
- depth, 8, entries per column FIFO; must be a power of 2, minimum 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- wr_i  input  col  per-column write strobe from the MAC array
- psum_in  input  psum_bw*col  column c data at bits [psum_bw*(c+1)-1 : psum_bw*c]
- rd_i  input  1  pop one aligned row (all columns)
- psum_out  output  psum_bw*col  head entry of every column, same lane packing; feeds the SFU psum_in
- valid_o  output  1  every column holds at least 1 entry
- full_o  output  1  any column holds depth entries
- ready_o  output  1  no column is full (equals ~full_o)
- ovf_o  output  1  sticky: a write hit a full column
- udf_o  output  1  sticky: rd_i was asserted while valid_o=0

Behaviour:
- Reset (asynchronous, active-high):
  - Takes effect immediately, including mid-operation; any buffered rows are discarded.
  - All read/write pointers and counts go to 0; valid_o=0, full_o=0, ready_o=1, ovf_o=0, udf_o=0, psum_out=0.
  - Storage arrays are not reset.
- Per column c:
  - Circular buffer with wptr, rptr (log2(depth) bits) and count (log2(depth)+1 bits).
  - Pointers wrap from depth-1 to 0 by natural overflow.
- Write:
  - When wr_i[c]=1 and count[c]<depth: store the lane at wptr[c] on the rising edge, then increment wptr and count.
  - Fullness is evaluated before any same-cycle pop. A write to a full column is dropped even if rd_i pops in that cycle. A dropped write sets ovf_o.
- Pop:
  - When rd_i=1 and valid_o=1: every column increments rptr and decrements count on the same edge.
  - When rd_i=1 and valid_o=0: no state change; udf_o is set.
- Simultaneous write and pop on a non-full column: count is unchanged, both pointers advance.
- Outputs:
  - valid_o, full_o and ready_o are combinational from the counts.
  - psum_out is first-word-fall-through: mem[c][rptr[c]] per lane, forced to 0 whenever valid_o=0.
- Latency: the edge that writes the last missing column makes valid_o=1 in the following cycle, with that row on psum_out. The consumer samples psum_out in the same cycle it asserts rd_i.
- Ordering: rows emerge in per-column write order. The k-th write to each column forms output row k.
- ovf_o and udf_o are cleared only by reset.

Decomposition:
- Shared accelerator package holds the constants COL=8, PSUM_BW=16 and OFIFO_DEPTH=8, plus a lane-slice helper function for packed-bus indexing.
- One sub-module, ofifo_col: a single-lane FIFO with ports clk, reset, wr, rd, din, dout, count.
- ofifo instantiates col copies of ofifo_col via generate. It derives valid_o and full_o by AND/OR reduction, and owns the sticky flags and the output zero-gating.

Test Plan:
- Aligned write: wr_i=8'hFF, lane c = c+1 (0x0001..0x0008) -> next cycle valid_o=1 and psum_out = 0x0008_0007_..._0001. Assert rd_i -> next cycle valid_o=0, psum_out=0.
- Skewed write:
  - Stimulus: 8 consecutive cycles; in cycle k, write only lane k with value 0x00A0+k.
  - valid_o stays 0 through the 8th write edge and rises the cycle after it; psum_out lanes = 0x00A0..0x00A7.
- Overflow:
  - Write lane 0 eight times (0x0010..0x0017) -> full_o=1, ready_o=0, valid_o=0.
  - 9th write (0x0018), even with rd_i=1 -> ovf_o=1; count stays 8.
  - Fill lanes 1-7, then pop 8 rows -> lane 0 reads 0x0010..0x0017 in order; 0x0018 never appears.
- Underflow: with the FIFO empty, rd_i=1 for 1 cycle -> udf_o=1 sticky; a subsequent aligned write/read still returns correct data.
- Wrap-around: 20 iterations of an aligned write of value i followed next cycle by a write plus simultaneous pop -> psum_out sequence 0,1,...,19 in every lane, full_o never asserts.
- Reset mid-operation:
  - Buffer 3 rows, then assert reset between clock edges -> valid_o=0 and psum_out=0 immediately, before the next edge.
  - After deassertion, one aligned write of 0x1234 in every lane returns 0x1234 in every lane.
